// File: rtl/serial_rx_buf.sv
// -----------------------------------------------------------------------------
// serial_rx_buf
//   Deserialises start-bit-framed serial flits (start '1', then DATA_W data bits
//   LSB first) into a DEPTH-entry first-word-fall-through buffer. A router input
//   port can keep accepting flits while earlier ones wait for the crossbar.
//
//   Build option: SERIAL_RX_PARITY_EN adds one even-parity bit after the data
//   bits, a PARITY state, and the parity_err output. Frames with bad parity are
//   dropped.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-low reset
//   serial_in    serial line, idle low
//   item_read    pop request; honoured only while valid is high
//   valid        buffer non-empty, parallel_out holds the head entry
//   parallel_out head entry, bit 0 = first data bit received
//   channel_busy upstream must not start a frame while high
//   count        occupancy, 0..DEPTH
//   overrun      one-cycle pulse when a start bit is dropped (buffer full)
//   parity_err   one-cycle pulse on a parity mismatch (parity build only)
//
// State table:
//   S_IDLE   | waiting for a start bit
//   S_SHIFT  | shifting in data bits
//   S_PARITY | checking the parity bit (parity build only)
// -----------------------------------------------------------------------------
module serial_rx_buf #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter     port   = "unknown"
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     serial_in,
   input  logic                     item_read,
   output logic                     valid,
   output logic [DATA_W-1:0]        parallel_out,
   output logic                     channel_busy,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overrun
`ifdef SERIAL_RX_PARITY_EN
   ,
   output logic                     parity_err
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(DATA_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("serial_rx_buf(%s): DEPTH=%0d must be a power of 2 and at least 2", port, DEPTH);
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2
   } state_t;

   state_t              state;
   logic [BW-1:0]       bit_cnt;
   logic [DATA_W-1:0]   shreg;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       rd_ptr;
   logic [AW-1:0]       wr_ptr;
   logic                full;
   logic                push;
   logic                pop;
   logic [DATA_W-1:0]   push_data;

   assign full         = (count == FULL_CNT);
   assign valid        = (count != '0);
   assign parallel_out = mem[rd_ptr];
   assign channel_busy = (state != S_IDLE) || full;
   assign pop          = valid && item_read;

   always_comb begin
      push      = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      // shreg already holds the whole flit; serial_in is the parity bit
      push_data = shreg;
      if (state == S_PARITY && (^{shreg, serial_in}) == 1'b0) begin
         push = 1'b1;
      end
`else
      // the last data bit goes straight into the MSB of the pushed word
      push_data = {serial_in, shreg[DATA_W-1:1]};
      if (state == S_SHIFT && bit_cnt == LAST_BIT) begin
         push = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         overrun <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (serial_in) begin
                  if (!full) begin
                     state   <= S_SHIFT;
                     bit_cnt <= '0;
                  end else begin
                     overrun <= 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               shreg   <= {serial_in, shreg[DATA_W-1:1]};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                  state <= S_PARITY;
`else
                  state <= S_IDLE;
`endif
               end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
               state <= S_IDLE;
               if ((^{shreg, serial_in}) != 1'b0) begin
                  parity_err <= 1'b1;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase

         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   // Storage carries no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (reset && push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: tb/tb_serial_rx_buf.sv
module tb_serial_rx_buf;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
`ifdef SERIAL_RX_PARITY_EN
   localparam int FL = DATA_W + 1;
`else
   localparam int FL = DATA_W;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              serial_in;
   logic              item_read;
   logic              valid;
   logic [DATA_W-1:0] parallel_out;
   logic              channel_busy;
   logic [2:0]        count;
   logic              overrun;
`ifdef SERIAL_RX_PARITY_EN
   logic              parity_err;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // reference model: FIFO contents in arrival order
   logic [DATA_W-1:0] q[$];

   serial_rx_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .port("tb")) dut (
      .clk          (clk),
      .reset        (reset),
      .serial_in    (serial_in),
      .item_read    (item_read),
      .valid        (valid),
      .parallel_out (parallel_out),
      .channel_busy (channel_busy),
      .count        (count),
      .overrun      (overrun)
`ifdef SERIAL_RX_PARITY_EN
      ,
      .parity_err   (parity_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Start bit, data bits LSB first, optional parity bit; returns right after
   // the final bit's edge. pop_end raises item_read during the final bit.
   task automatic send_frame(input logic [DATA_W-1:0] d, input bit pop_end, input bit bad_par);
      serial_in = 1'b1;
      tick();
      for (int i = 0; i < FL; i++) begin
         if (i < DATA_W) serial_in = d[i];
         else            serial_in = (^d) ^ bad_par;
         item_read = pop_end && (i == FL - 1);
         tick();
      end
      serial_in = 1'b0;
      item_read = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; serial_in = 1'b0; item_read = 1'b0;
      tick(); tick();
      tests_run++;
      if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", count); end
      tests_run++;
      if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", valid); end
      tests_run++;
      if (channel_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", channel_busy); end
      tests_run++;
      if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      reset = 1'b1;
      q.delete();
   endtask

   task automatic test_single_frame;
      logic [DATA_W-1:0] d;
      d = 16'hA5C3;
      repeat (7) tick();
      serial_in = 1'b1;
      tick();
      tests_run++;
      if (channel_busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_start got=%b exp=1", channel_busy); end
      for (int i = 0; i < FL; i++) begin
         if (i < DATA_W) serial_in = d[i];
         else            serial_in = ^d;
         tick();
         tests_run++;
         if (channel_busy !== (i < FL - 1)) begin
            tests_failed++;
            $display("FAIL single_busy bit=%0d got=%b exp=%b", i, channel_busy, (i < FL - 1));
         end
         tests_run++;
         if (valid !== (i == FL - 1)) begin
            tests_failed++;
            $display("FAIL single_valid bit=%0d got=%b exp=%b", i, valid, (i == FL - 1));
         end
      end
      serial_in = 1'b0;
      tests_run++;
      if (parallel_out !== d) begin tests_failed++; $display("FAIL single_data got=%h exp=%h", parallel_out, d); end
      tests_run++;
      if (count !== 3'd1) begin tests_failed++; $display("FAIL single_count got=%0d exp=1", count); end
      item_read = 1'b1; tick(); item_read = 1'b0;
      tests_run++;
      if (valid !== 1'b0) begin tests_failed++; $display("FAIL single_pop_valid got=%b exp=0", valid); end
   endtask

   task automatic test_fill_full;
      for (int i = 1; i <= DEPTH; i++) send_frame(DATA_W'(i), 1'b0, 1'b0);
      tests_run++;
      if (count !== 3'd4) begin tests_failed++; $display("FAIL full_count got=%0d exp=4", count); end
      tick();
      tests_run++;
      if (channel_busy !== 1'b1) begin tests_failed++; $display("FAIL full_busy got=%b exp=1", channel_busy); end
      for (int i = 1; i <= DEPTH; i++) begin
         tests_run++;
         if (valid !== 1'b1 || parallel_out !== DATA_W'(i)) begin
            tests_failed++;
            $display("FAIL full_pop%0d got valid=%b data=%h exp valid=1 data=%h", i, valid, parallel_out, DATA_W'(i));
         end
         item_read = 1'b1; tick(); item_read = 1'b0;
         tests_run++;
         if (channel_busy !== 1'b0) begin tests_failed++; $display("FAIL full_busy_after_pop%0d got=%b exp=0", i, channel_busy); end
      end
      tests_run++;
      if (valid !== 1'b0 || count !== 3'd0) begin
         tests_failed++;
         $display("FAIL full_drained got valid=%b count=%0d exp valid=0 count=0", valid, count);
      end
   endtask

   task automatic test_push_pop;
      send_frame(16'h1111, 1'b0, 1'b0);
      tests_run++;
      if (count !== 3'd1 || parallel_out !== 16'h1111) begin
         tests_failed++;
         $display("FAIL pushpop_setup got count=%0d data=%h exp count=1 data=1111", count, parallel_out);
      end
      send_frame(16'h2222, 1'b1, 1'b0);
      tests_run++;
      if (count !== 3'd1 || valid !== 1'b1 || parallel_out !== 16'h2222) begin
         tests_failed++;
         $display("FAIL pushpop got count=%0d valid=%b data=%h exp count=1 valid=1 data=2222", count, valid, parallel_out);
      end
      item_read = 1'b1; tick(); item_read = 1'b0;
   endtask

   task automatic test_overrun;
      logic [DATA_W-1:0] d;
      q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         d = DATA_W'($urandom);
         send_frame(d, 1'b0, 1'b0);
         q.push_back(d);
      end
      serial_in = 1'b1; tick(); serial_in = 1'b0;
      tests_run++;
      if (overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_pulse got=%b exp=1", overrun); end
      tick();
      tests_run++;
      if (overrun !== 1'b0) begin tests_failed++; $display("FAIL overrun_width got=%b exp=0", overrun); end
      tests_run++;
      if (count !== 3'd4) begin tests_failed++; $display("FAIL overrun_count got=%0d exp=4", count); end
      while (q.size() > 0) begin
         tests_run++;
         if (parallel_out !== q[0]) begin
            tests_failed++;
            $display("FAIL overrun_contents got=%h exp=%h", parallel_out, q[0]);
         end
         void'(q.pop_front());
         item_read = 1'b1; tick(); item_read = 1'b0;
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [DATA_W-1:0] d;
      d = 16'h1234;
      serial_in = 1'b1; tick();
      for (int i = 0; i < 7; i++) begin serial_in = d[i]; tick(); end
      reset = 1'b0; serial_in = d[7]; tick();
      reset = 1'b1; serial_in = 1'b0;
      tests_run++;
      if (count !== 3'd0 || channel_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset got count=%0d busy=%b exp count=0 busy=0", count, channel_busy);
      end
      tick();
      send_frame(16'hBEEF, 1'b0, 1'b0);
      tests_run++;
      if (count !== 3'd1 || parallel_out !== 16'hBEEF) begin
         tests_failed++;
         $display("FAIL midreset_frame got count=%0d data=%h exp count=1 data=beef", count, parallel_out);
      end
      item_read = 1'b1; tick(); item_read = 1'b0;
      q.delete();
   endtask

`ifdef SERIAL_RX_PARITY_EN
   task automatic test_parity;
      send_frame(16'h0003, 1'b0, 1'b0);
      tests_run++;
      if (count !== 3'd1 || parallel_out !== 16'h0003 || parity_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL parity_good got count=%0d data=%h perr=%b exp 1/0003/0", count, parallel_out, parity_err);
      end
      send_frame(16'h0003, 1'b0, 1'b1);
      tests_run++;
      if (count !== 3'd1 || parity_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL parity_bad got count=%0d perr=%b exp count=1 perr=1", count, parity_err);
      end
      tick();
      tests_run++;
      if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL parity_err_width got=%b exp=0", parity_err); end
      item_read = 1'b1; tick(); item_read = 1'b0;
   endtask
`endif

   task automatic test_random;
      logic [DATA_W-1:0] d;
      bit                pe;
      int                op;
      q.delete();
      for (int it = 0; it < 60; it++) begin
         op = $urandom_range(0, 3);
         if (op <= 1) begin
            if (q.size() < DEPTH) begin
               d  = DATA_W'($urandom);
               pe = $urandom_range(0, 1);
               send_frame(d, pe, 1'b0);
               if (pe && q.size() > 0) void'(q.pop_front());
               q.push_back(d);
            end else begin
               serial_in = 1'b1; tick(); serial_in = 1'b0;
               tests_run++;
               if (overrun !== 1'b1) begin tests_failed++; $display("FAIL rand_overrun it=%0d got=%b exp=1", it, overrun); end
            end
         end else if (op == 2) begin
            item_read = 1'b1; tick(); item_read = 1'b0;
            if (q.size() > 0) void'(q.pop_front());
         end else begin
            repeat ($urandom_range(1, 3)) tick();
         end
         tests_run++;
         if (count !== 3'(q.size()) || valid !== (q.size() != 0) || channel_busy !== (q.size() == DEPTH)) begin
            tests_failed++;
            $display("FAIL rand_state it=%0d got count=%0d valid=%b busy=%b exp count=%0d", it, count, valid, channel_busy, q.size());
         end
         if (q.size() > 0) begin
            tests_run++;
            if (parallel_out !== q[0]) begin
               tests_failed++;
               $display("FAIL rand_head it=%0d got=%h exp=%h", it, parallel_out, q[0]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_fill_full();
      test_push_pop();
      test_overrun();
      test_reset_mid_frame();
`ifdef SERIAL_RX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
